sobel_window_filter: RTL and testbench

- Next-generation 3x3 window operator for the pixel stream pipeline; it sits downstream of the line-buffer window generator.
- Replaces the centre-pixel passthrough with a selectable per-beat mode: passthrough, |Gx|, |Gy| or |Gx|+|Gy|.
- Adds a per-beat right-shift scale, saturation and fixed-latency valid tracking.
- Parametrised in pixel width. Output keeps the packed {valid, pixel} format.

---
 rtl/sobel_pkg.sv | 33 +++
 rtl/sobel_window_filter_abs_val.sv | 12 +
 rtl/sobel_window_filter.sv | 123 ++++++++++++
 tb/tb_sobel_window_filter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel window filter: mode encoding, beat tag,
// pipeline latency and the saturating clamp used on the output stage.
package sobel_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_GX   = 2'd1,
        MODE_GY   = 2'd2,
        MODE_MAG  = 2'd3
    } mode_e;

    localparam int LAT = 4;

    // mode and shift ride alongside the beat so every stage sees its own controls
    typedef struct packed {
        mode_e      mode;
        logic [1:0] shift;
    } tag_t;

    // Clamp an in_w-bit unsigned value into out_w bits.
    function automatic logic [31:0] saturate(input logic [31:0] val,
                                             input int unsigned in_w,
                                             input int unsigned out_w);
        logic [31:0] in_mask;
        logic [31:0] max_v;
        logic [31:0] v;
        in_mask = (in_w >= 32) ? '1 : ((32'd1 << in_w) - 32'd1);
        max_v   = (32'd1 << out_w) - 32'd1;
        v       = val & in_mask;
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/sobel_window_filter_abs_val.sv
// Absolute-value unit: signed W-bit input to unsigned (W-1)-bit magnitude.
// The most-negative input is never presented, so W-1 bits always suffice.
module abs_val #(
    parameter int W = 8
) (
    input  logic signed [W-1:0] a,
    output logic        [W-2:0] mag
);

    assign mag = a[W-1] ? (~a[W-2:0] + (W-1)'(1)) : a[W-2:0];

endmodule

// File: rtl/sobel_window_filter.sv
// Four-stage 3x3 Sobel operator with per-beat mode/shift, saturation and
// fixed-latency valid tracking. Output is packed {valid, pixel}.
module sobel_window_filter #(
    parameter int PIX_W    = 8,
    parameter int OPE_SIZE = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      reflesh,
    input  logic [1:0]                                mode,
    input  logic [1:0]                                shift,
    input  logic [OPE_SIZE*OPE_SIZE*(PIX_W+1)-1:0]    data_bus,
    output logic [PIX_W:0]                            out
);
    import sobel_pkg::*;

    localparam int EW  = PIX_W + 1;
    localparam int SW  = PIX_W + 2;
    localparam int DW  = PIX_W + 3;
    localparam int CTR = (OPE_SIZE * OPE_SIZE) / 2;

    if (OPE_SIZE != 3) begin : g_size_check
        $error("sobel_window_filter: OPE_SIZE must be 3");
    end

    logic [PIX_W-1:0] p [OPE_SIZE][OPE_SIZE];
    logic             valid_in;
    logic             flush;
    logic             unused_valid;

    always_comb begin
        for (int y = 0; y < OPE_SIZE; y++) begin
            for (int x = 0; x < OPE_SIZE; x++) begin
                p[y][x] = data_bus[(y*OPE_SIZE+x)*EW +: PIX_W];
            end
        end
    end

    assign valid_in = data_bus[CTR*EW + PIX_W];
    assign flush    = rst | reflesh;

    // Only the centre valid qualifies a beat; the rest are deliberately ignored.
    always_comb begin
        unused_valid = 1'b0;
        for (int i = 0; i < OPE_SIZE*OPE_SIZE; i++) begin
            if (i != CTR) unused_valid = unused_valid ^ data_bus[i*EW + PIX_W];
        end
    end

    function automatic logic [SW-1:0] wsum(input logic [PIX_W-1:0] a,
                                           input logic [PIX_W-1:0] b,
                                           input logic [PIX_W-1:0] c);
        return SW'(a) + (SW'(b) << 1) + SW'(c);
    endfunction

    // Stage registers
    logic                  s1_v, s2_v, s3_v;
    tag_t                  s1_tag, s2_tag, s3_tag;
    logic [PIX_W-1:0]      s1_c, s2_c, s3_c;
    logic [SW-1:0]         s1_gxp, s1_gxn, s1_gyp, s1_gyn;
    logic signed [DW-1:0]  s2_dx, s2_dy;
    logic [SW-1:0]         s3_ax, s3_ay;
    logic [DW-1:0]         s3_sum;

    logic [SW-1:0]         ax, ay;
    logic [DW-1:0]         sel, shifted;
    logic [PIX_W-1:0]      res;

    abs_val #(.W(DW)) u_abs_x (.a(s2_dx), .mag(ax));
    abs_val #(.W(DW)) u_abs_y (.a(s2_dy), .mag(ay));

    always_comb begin
        sel = '0;
        case (s3_tag.mode)
            MODE_PASS: sel = DW'(s3_c);
            MODE_GX:   sel = DW'(s3_ax);
            MODE_GY:   sel = DW'(s3_ay);
            MODE_MAG:  sel = s3_sum;
            default:   sel = '0;
        endcase
        shifted = (s3_tag.mode == MODE_PASS) ? sel : (sel >> s3_tag.shift);
        res     = PIX_W'(saturate(32'(shifted), DW, PIX_W));
    end

    // NOTE: flush is synchronous and clears data as well as valids, so a
    // restarted frame never sees stale tags or partial sums.
    always_ff @(posedge clk) begin
        if (flush) begin
            s1_v   <= 1'b0;  s2_v   <= 1'b0;  s3_v   <= 1'b0;
            s1_tag <= '0;    s2_tag <= '0;    s3_tag <= '0;
            s1_c   <= '0;    s2_c   <= '0;    s3_c   <= '0;
            s1_gxp <= '0;    s1_gxn <= '0;
            s1_gyp <= '0;    s1_gyn <= '0;
            s2_dx  <= '0;    s2_dy  <= '0;
            s3_ax  <= '0;    s3_ay  <= '0;    s3_sum <= '0;
            out    <= '0;
        end else begin
            s1_v   <= valid_in;
            s1_tag <= '{mode: mode_e'(mode), shift: shift};
            s1_c   <= p[1][1];
            s1_gxp <= wsum(p[0][2], p[1][2], p[2][2]);
            s1_gxn <= wsum(p[0][0], p[1][0], p[2][0]);
            s1_gyp <= wsum(p[2][0], p[2][1], p[2][2]);
            s1_gyn <= wsum(p[0][0], p[0][1], p[0][2]);

            s2_v   <= s1_v;
            s2_tag <= s1_tag;
            s2_c   <= s1_c;
            s2_dx  <= $signed({1'b0, s1_gxp}) - $signed({1'b0, s1_gxn});
            s2_dy  <= $signed({1'b0, s1_gyp}) - $signed({1'b0, s1_gyn});

            s3_v   <= s2_v;
            s3_tag <= s2_tag;
            s3_c   <= s2_c;
            s3_ax  <= ax;
            s3_ay  <= ay;
            s3_sum <= {1'b0, ax} + {1'b0, ay};

            out    <= {s3_v, s3_v ? res : {PIX_W{1'b0}}};
        end
    end

endmodule

// File: tb/tb_sobel_window_filter.sv
// Directed bench for sobel_window_filter: reset, gradient modes, saturation,
// per-beat mode tagging in a stream, and mid-stream reflesh/rst flushes.
module tb_sobel_window_filter;

    localparam int PIX_W = 8;
    localparam int BUS_W = 9 * (PIX_W + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             reflesh;
    logic [1:0]       mode;
    logic [1:0]       shift;
    logic [BUS_W-1:0] data_bus;
    logic [PIX_W:0]   out;

    int total = 0;
    int bad   = 0;

    sobel_window_filter #(.PIX_W(PIX_W), .OPE_SIZE(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .reflesh  (reflesh),
        .mode     (mode),
        .shift    (shift),
        .data_bus (data_bus),
        .out      (out)
    );

    always #5 clk = ~clk;

    function automatic logic [BUS_W-1:0] mk(
        input logic [7:0] p00, input logic [7:0] p01, input logic [7:0] p02,
        input logic [7:0] p10, input logic [7:0] p11, input logic [7:0] p12,
        input logic [7:0] p20, input logic [7:0] p21, input logic [7:0] p22,
        input logic vc);
        logic [7:0]       px [9];
        logic [BUS_W-1:0] b;
        px[0] = p00; px[1] = p01; px[2] = p02;
        px[3] = p10; px[4] = p11; px[5] = p12;
        px[6] = p20; px[7] = p21; px[8] = p22;
        b = '0;
        for (int i = 0; i < 9; i++) b[i*9 +: 9] = {(i == 4) ? vc : 1'b1, px[i]};
        return b;
    endfunction

    task automatic drive(input logic [BUS_W-1:0] bus, input logic [1:0] m, input logic [1:0] s);
        data_bus = bus;
        mode     = m;
        shift    = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            drive('0, 2'd0, 2'd0);
        end
    endtask

    // One beat into an empty pipe: still 0 at t+3, expected value at t+4.
    task automatic single_beat(input string name, input logic [BUS_W-1:0] bus,
                               input logic [1:0] m, input logic [1:0] s,
                               input logic [PIX_W:0] exp);
        idle(4);
        @(negedge clk);
        drive(bus, m, s);
        @(negedge clk);
        drive('0, 2'd0, 2'd0);
        repeat (2) @(negedge clk);
        total++;
        if (out !== 9'h000) begin
            bad++;
            $display("FAIL %s_early: got %h want %h", name, out, 9'h000);
        end
        @(negedge clk);
        total++;
        if (out !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, out, exp);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        reflesh = 1'b0;
        drive(mk(100,100,100,100,100,100,100,100,100,1'b1), 2'd0, 2'd0);
        repeat (5) begin
            @(negedge clk);
            total++;
            if (out !== 9'h000) begin
                bad++;
                $display("FAIL reset_out: got %h want %h", out, 9'h000);
            end
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_flat();
        single_beat("flat_mag", mk(100,100,100,100,100,100,100,100,100,1'b1), 2'd3, 2'd0, 9'h100);
    endtask

    task automatic test_vertical_edge();
        logic [BUS_W-1:0] w;
        w = mk(0,128,255, 0,128,255, 0,128,255, 1'b1);
        single_beat("vedge_gx_s0_sat", w, 2'd1, 2'd0, 9'h1FF);
        single_beat("vedge_gx_s3",     w, 2'd1, 2'd3, 9'h17F);
        single_beat("vedge_gy",        w, 2'd2, 2'd0, 9'h100);
        w = mk(255,128,0, 255,128,0, 255,128,0, 1'b1);
        single_beat("mirror_gx_s2",    w, 2'd1, 2'd2, 9'h1FF);
    endtask

    task automatic test_corner();
        logic [BUS_W-1:0] w;
        w = mk(0,0,255, 0,255,255, 255,255,255, 1'b1);
        single_beat("corner_mag_s3", w, 2'd3, 2'd3, 9'h1BF);
        single_beat("corner_pass",   w, 2'd0, 2'd3, 9'h1FF);
        single_beat("corner_invalid", mk(0,0,255, 0,255,255, 255,255,255, 1'b0), 2'd0, 2'd0, 9'h000);
    endtask

    // Ten beats on an asymmetric window (dx=400, dy=80, sum=480, shift 1),
    // mode = i%4, centre = 20+i. flush_at<0 disables the flush pulse.
    task automatic run_stream(input string name, input int inval_at,
                              input int flush_at, input bit use_rst);
        logic [PIX_W:0] exp [10];
        for (int i = 0; i < 10; i++) begin
            case (i % 4)
                0: exp[i] = {1'b1, 8'(20 + i)};
                1: exp[i] = {1'b1, 8'd200};
                2: exp[i] = {1'b1, 8'd40};
                default: exp[i] = {1'b1, 8'd240};
            endcase
            if (i == inval_at) exp[i] = 9'h000;
            if (flush_at >= 0 && i >= flush_at - 3 && i <= flush_at) exp[i] = 9'h000;
        end
        idle(4);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k >= 4) begin
                total++;
                if (out !== exp[k-4]) begin
                    bad++;
                    $display("FAIL %s_beat%0d: got %h want %h", name, k - 4, out, exp[k-4]);
                end
            end
            rst     = use_rst  && (k == flush_at);
            reflesh = !use_rst && (k == flush_at);
            if (k < 10)
                drive(mk(0,0,100, 0,8'(20 + k),100, 0,40,100, (k != inval_at)),
                      2'(k % 4), 2'd1);
            else
                drive('0, 2'd0, 2'd0);
        end
        rst     = 1'b0;
        reflesh = 1'b0;
    endtask

    task automatic test_stream();
        run_stream("stream", 5, -1, 1'b0);
    endtask

    task automatic test_reflesh();
        run_stream("reflesh", -1, 5, 1'b0);
    endtask

    task automatic test_rst_mid();
        run_stream("rst_mid", -1, 5, 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        reflesh  = 1'b0;
        mode     = 2'd0;
        shift    = 2'd0;
        data_bus = '0;
        test_reset();
        test_flat();
        test_vertical_edge();
        test_corner();
        test_stream();
        test_reflesh();
        test_rst_mid();
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
